pla_subcube_sweep_ctrl: RTL
===========================

// Module: pla_subcube_sweep_ctrl
// PURPOSE
//  Sequencer that drives a synthesized single-output PLA function core (x0..x14 -> y0) through every
//  minterm of a restricted subcube: variables selected by fix_mask are held at fix_val, and all free
//  variables are enumerated. It accumulates the on-set size and visited count, which feed the
//  autosymmetry/restriction experiments. The core is external and combinational or pipelined.
// PARAMETERS
//  NIN   15        number of core inputs
//  LAT   0         core latency in cycles: core_y belongs to core_x driven LAT cycles earlier (0..7)
//  CNTW  NIN+1     counter width; must hold 2**NIN
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     asynchronous, active-high reset
//  start      in   1     pulse; sampled only in IDLE; latches fix_mask/fix_val
//  abort      in   1     pulse; terminates the sweep; done is not raised
//  fix_mask   in   NIN   1 = variable held at fix_val, 0 = enumerated
//  fix_val    in   NIN   values for the held variables (bits where fix_mask=0 are ignored)
//  core_x     out  NIN   input vector to the PLA core
//  core_y     in   1     core output, aligned per LAT
//  busy       out  1     high in RUN and DRAIN
//  done       out  1     one-cycle pulse when a sweep completes normally
//  onset_cnt  out  CNTW  number of visited vectors with core_y=1
//  visit_cnt  out  CNTW  number of vectors whose core_y has been sampled
//  sig        out  16    MISR signature (only with PLA_SWEEP_SIG_EN; otherwise tied to 0)
// BEHAVIOUR
//  Reset: state=IDLE; core_x=0; busy=0; done=0; onset_cnt=0; visit_cnt=0; sig=16'hFFFF; valid pipe=0.
//  States: IDLE -> RUN (on start) -> DRAIN (after the last vector is issued) -> DONE (after the
//   pipe is empty) -> IDLE. DONE lasts exactly 1 cycle, and done=1 only in that cycle.
//  start in IDLE: latch mask/val; clear both counts and sig; first vector = fix_val & fix_mask.
//  RUN: one vector per cycle. next = (((cur | m) + 1) & ~m) | (v & m), with m=mask, v=val.
//   The last vector is the one whose free bits are all 1. When the free part wraps to 0 -> DRAIN.
//  fix_mask all ones: exactly 1 vector; RUN lasts 1 cycle.
//  A valid bit shifts through an LAT-deep pipe alongside the issue. When a valid bit exits the
//   pipe, visit_cnt++, and onset_cnt++ if core_y=1. With LAT=0, core_y is sampled in the cycle
//   core_x is driven.
//  DRAIN: no issue; core_x holds its last value; wait until the valid pipe is empty.
//  Totals: visit_cnt = 2**(number of zeros in mask) at DONE. Counts hold until the next start.
//  start while busy: ignored. start and abort in the same IDLE cycle: abort wins, so the sweep
//   does not start.
//  abort in RUN/DRAIN: go to IDLE next cycle; flush the valid pipe; counts keep their partial
//   values; done stays 0.
//  rst mid-sweep: immediate return to reset values; no done.
//  Latency from start to done = 2**free + LAT + 1 cycles (start sampled -> done high).
// CONFIGURATION
//  PLA_SWEEP_SIG_EN defined: 16-bit MISR with polynomial x^16+x^12+x^5+1, seed 16'hFFFF, cleared
//   on start. Each sampled core_y is XORed into bit 0 on every visit.
//  PLA_SWEEP_SIG_EN undefined: no MISR logic; sig is driven 16'h0000.
// STRUCTURE
//  Package pla_sweep_pkg holds: the state enum (IDLE, RUN, DRAIN, DONE), NIN_DEF=15, MISR_POLY,
//   MISR_SEED.
//  Sub-module pla_subcube_enum: masked-increment enumerator. Inputs: cur, mask, val.
//   Outputs: next, last. Purely combinational.
//  Top level: FSM, valid pipe, counters, optional MISR.
// TESTING
//  Core y=x0, LAT=0, mask=0 -> visit_cnt=32768, onset_cnt=16384, done 32769 cycles after start.
//  mask=15'h7FFF, val=15'h1234, core y=^x -> one vector 15'h1234; visit=1; onset=1; done at cycle 2.
//  mask=15'h7FF0, val=15'h0050, LAT=3, core y=x0&x1 -> vectors 0x50..0x5F in order; visit=16;
//   onset=4; done at cycle 20.
//  abort at cycle 100 of a mask=0 sweep -> IDLE next cycle; done never pulses; visit_cnt=100.
//  start pulsed during RUN -> ignored; the sweep and its counts are unchanged.
//  rst asserted mid-DRAIN -> all outputs at reset values asynchronously; a new start then runs
//   cleanly.
//  PLA_SWEEP_SIG_EN, y=0, mask=15'h7FFE -> sig equals the reference model after 2 shifts.

Source files
------------

// File: rtl/pla_sweep_pkg.sv
// Shared types and constants for the PLA subcube sweep controller.
// The MISR constants and step function matter only in builds with
// PLA_SWEEP_SIG_EN defined.
package pla_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          NIN_DEF   = 15;
  // x^16 + x^12 + x^5 + 1; the x^16 term is the implicit feedback tap
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // One MISR shift: Galois feedback from bit 15, new data XORed into bit 0
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic d);
    return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ {15'h0000, d};
  endfunction

endpackage

// File: rtl/pla_subcube_enum.sv
// Masked-increment enumerator. Held bits are forced to 1 before the +1, so
// the carry ripples straight through them into the next free bit. The held
// bits are then put back to their fixed values. last marks the vector whose
// free bits are all ones: the next increment wraps the free part to zero.
module pla_subcube_enum
  import pla_sweep_pkg::*;
#(
  parameter int NIN = NIN_DEF
) (
  input  logic [NIN-1:0] cur,
  input  logic [NIN-1:0] mask,
  input  logic [NIN-1:0] val,
  output logic [NIN-1:0] next,
  output logic           last
);

  logic [NIN-1:0] bumped;

  // Carry skips over held bits because they are pre-set to one
  assign bumped = (cur | mask) + {{(NIN-1){1'b0}}, 1'b1};
  assign next   = (bumped & ~mask) | (val & mask);
  assign last   = &(cur | mask);

endmodule

// File: rtl/pla_subcube_sweep_ctrl.sv
// Sweeps an external PLA core over every minterm of a restricted subcube.
// It counts the vectors it visits and those with core_y = 1.
// Build option: define PLA_SWEEP_SIG_EN to add a 16-bit MISR on the sampled
// core_y stream. Without it, sig is tied to zero.
//
// state | meaning
// IDLE  | waiting for start; counts and sig hold their last values
// RUN   | one vector issued per cycle, in ascending order of the free bits
// DRAIN | issue stopped; waiting for in-flight core_y samples to arrive
// DONE  | single cycle with done=1, then back to IDLE
module pla_subcube_sweep_ctrl
  import pla_sweep_pkg::*;
#(
  parameter int NIN  = NIN_DEF,
  parameter int LAT  = 0,
  parameter int CNTW = NIN + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [NIN-1:0]  fix_mask,
  input  logic [NIN-1:0]  fix_val,
  output logic [NIN-1:0]  core_x,
  input  logic            core_y,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] onset_cnt,
  output logic [CNTW-1:0] visit_cnt,
  output logic [15:0]     sig
);

  state_t         state;
  logic [NIN-1:0] mask_q;
  logic [NIN-1:0] val_q;
  logic [NIN-1:0] nxt;
  logic           last_vec;
  logic           accept;
  logic           issue;
  logic           vexit;
  logic           pipe_busy;

  // abort has priority over start, even in the same IDLE cycle
  assign accept = (state == IDLE) && start && !abort;
  assign issue  = (state == RUN);

  pla_subcube_enum #(.NIN(NIN)) u_enum (
    .cur  (core_x),
    .mask (mask_q),
    .val  (val_q),
    .next (nxt),
    .last (last_vec)
  );

  // Sequencer: one vector per RUN cycle, then drain, then a one-cycle done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mask_q <= '0;
      val_q  <= '0;
      core_x <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mask_q <= fix_mask;
            val_q  <= fix_val;
            core_x <= fix_val & fix_mask;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (last_vec) begin
            state <= DRAIN;
          end else begin
            core_x <= nxt;
          end
        end
        DRAIN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (!pipe_busy) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Valid tracking: a token issued with core_x reaches the counters when core_y is valid
  generate
    if (LAT == 0) begin : g_nopipe
      assign vexit     = issue;
      assign pipe_busy = 1'b0;
    end else begin : g_pipe
      logic [LAT-1:0] vpipe;

      // Shift the issue token in; abort discards everything in flight
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vpipe <= '0;
        end else if (abort) begin
          vpipe <= '0;
        end else begin
          vpipe <= (vpipe << 1) | LAT'(issue);
        end
      end

      assign vexit     = vpipe[LAT-1];
      assign pipe_busy = |vpipe;
    end
  endgenerate

  // Visit and on-set counters: cleared on an accepted start; otherwise they hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      visit_cnt <= '0;
      onset_cnt <= '0;
    end else if (accept) begin
      visit_cnt <= '0;
      onset_cnt <= '0;
    end else if (vexit) begin
      visit_cnt <= visit_cnt + CNTW'(1);
      if (core_y) begin
        onset_cnt <= onset_cnt + CNTW'(1);
      end
    end
  end

`ifdef PLA_SWEEP_SIG_EN
  logic [15:0] sig_q;

  // Signature: reseeded on start, one shift per sampled core_y
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= MISR_SEED;
    end else if (accept) begin
      sig_q <= MISR_SEED;
    end else if (vexit) begin
      sig_q <= misr_step(sig_q, core_y);
    end
  end

  assign sig = sig_q;
`else
  assign sig = 16'h0000;
`endif

endmodule
